// File: rtl/crs_col_gen.sv
// ---------------------------------------------------------------------------
// crs_col_gen
//   Multi-channel carrier-sense / collision generator for the 1G MAC and
//   repeater datapath.
//
//   Per channel:
//     - crs: registered carrier sense. After activity ends, it can be held
//       high for a programmable number of cycles (carrier extension / IPG
//       guard). This uses a three-state FSM (OFF, ON, HOLD) and a hold
//       counter.
//     - col: registered collision. Once asserted it stays high for at least
//       COL_MIN cycles, enforced by a stretch counter.
//   Shared:
//     - crs_any / col_any: registered ORs of the channel outputs. They
//       update on the same edge as crs / col.
//
// Parameters
//   NCH      number of channels (>= 1)
//   HOLD_W   width of hold_cycles and of each hold counter
//   COL_MIN  minimum col high time in cycles (>= 1)
//
// Ports
//   clk            clock
//   reset          synchronous, active-high
//   repeater_mode  1 = repeater: own tx ignored for crs, col = rx contention
//   half_duplex    1 = collision generation enabled in MAC mode
//   tx, rx         per-channel transmit / receive activity
//   hold_cycles    crs hold after activity ends (0 = no hold)
//   crs, col       per-channel carrier sense / collision
//   crs_any        |crs
//   col_any        |col
// ---------------------------------------------------------------------------
module crs_col_gen #(
  parameter int NCH     = 4,
  parameter int HOLD_W  = 8,
  parameter int COL_MIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              repeater_mode,
  input  logic              half_duplex,
  input  logic [NCH-1:0]    tx,
  input  logic [NCH-1:0]    rx,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [NCH-1:0]    crs,
  output logic [NCH-1:0]    col,
  output logic              crs_any,
  output logic              col_any
);

  // The stretch counter must be able to hold the value COL_MIN-1.
  localparam int CW = $clog2(COL_MIN + 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } crs_state_t;

  crs_state_t        state      [NCH];
  logic [HOLD_W-1:0] hold_cnt   [NCH];
  logic [CW-1:0]     str_cnt    [NCH];
  logic [NCH-1:0]    c_prev;

  crs_state_t        state_nx   [NCH];
  logic [HOLD_W-1:0] hold_cnt_nx[NCH];
  logic [CW-1:0]     str_cnt_nx [NCH];
  logic [NCH-1:0]    act;
  logic [NCH-1:0]    c;
  logic [NCH-1:0]    crs_nx;
  logic [NCH-1:0]    col_nx;
  int                rx_count;

  // Activity and collision conditions, evaluated fresh each cycle.
  // A change of repeater_mode therefore affects act/c at the very next edge.
  // NOTE: every signal written in always_comb gets a default value first.
  // Without it, a path that leaves the signal unassigned infers a latch.
  always_comb begin
    rx_count = 0;
    for (int i = 0; i < NCH; i++) begin
      rx_count += int'(rx[i]);
    end
    act = '0;
    c   = '0;
    for (int i = 0; i < NCH; i++) begin
      act[i] = (!repeater_mode && tx[i]) || rx[i];
      if (repeater_mode) begin
        c[i] = rx[i] && (rx_count >= 2);
      end else begin
        c[i] = half_duplex && tx[i] && rx[i];
      end
    end
  end

  // Next-state logic for the carrier FSM and the collision stretch.
  always_comb begin
    crs_nx = '0;
    col_nx = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nx[i]    = state[i];
      hold_cnt_nx[i] = hold_cnt[i];
      str_cnt_nx[i]  = str_cnt[i];

      unique case (state[i])
        ST_OFF: begin
          if (act[i]) state_nx[i] = ST_ON;
        end
        ST_ON: begin
          if (!act[i]) begin
            if (hold_cycles == '0) begin
              state_nx[i] = ST_OFF;
            end else begin
              // hold_cycles is sampled only here. Later changes do not
              // affect a hold that is already running.
              state_nx[i]    = ST_HOLD;
              hold_cnt_nx[i] = hold_cycles;
            end
          end
        end
        ST_HOLD: begin
          // Retrigger takes priority over expiry.
          if (act[i]) begin
            state_nx[i]    = ST_ON;
            hold_cnt_nx[i] = '0;
          end else if (hold_cnt[i] == HOLD_W'(1)) begin
            state_nx[i]    = ST_OFF;
            hold_cnt_nx[i] = '0;
          end else begin
            hold_cnt_nx[i] = hold_cnt[i] - HOLD_W'(1);
          end
        end
        default: begin
          state_nx[i]    = ST_OFF;
          hold_cnt_nx[i] = '0;
        end
      endcase
      crs_nx[i] = (state_nx[i] != ST_OFF);

      // The stretch counter holds the minimum-width cycles still owed after
      // the current one. It reloads on a new collision event, including one
      // that arrives during a stretch. It keeps counting down while c stays
      // high, so col lasts max(duration of c, COL_MIN) cycles.
      if (c[i] && !c_prev[i]) begin
        str_cnt_nx[i] = CW'(COL_MIN - 1);
      end else if (str_cnt[i] != '0) begin
        str_cnt_nx[i] = str_cnt[i] - CW'(1);
      end
      col_nx[i] = c[i] || (str_cnt[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Blocking
  // assignments here would create simulation order races between blocks.
  // NOTE: the counters are reset individually with their owners. They are
  // per-channel flops, not a memory array, so resetting them costs nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]    <= ST_OFF;
        hold_cnt[i] <= '0;
        str_cnt[i]  <= '0;
      end
      c_prev  <= '0;
      crs     <= '0;
      col     <= '0;
      crs_any <= 1'b0;
      col_any <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]    <= state_nx[i];
        hold_cnt[i] <= hold_cnt_nx[i];
        str_cnt[i]  <= str_cnt_nx[i];
      end
      c_prev  <= c;
      crs     <= crs_nx;
      col     <= col_nx;
      crs_any <= |crs_nx;
      col_any <= |col_nx;
    end
  end

endmodule

// File: tb/tb_crs_col_gen.sv
// ---------------------------------------------------------------------------
// tb_crs_col_gen
//   Directed testbench for crs_col_gen (NCH=4, HOLD_W=8, COL_MIN=4).
//   Inputs are driven with blocking assignments. Outputs are checked 1 ns
//   after each rising edge. All expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_crs_col_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       repeater_mode;
  logic       half_duplex;
  logic [3:0] tx;
  logic [3:0] rx;
  logic [7:0] hold_cycles;
  logic [3:0] crs;
  logic [3:0] col;
  logic       crs_any;
  logic       col_any;

  int total = 0;
  int bad   = 0;

  crs_col_gen #(.NCH(4), .HOLD_W(8), .COL_MIN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .repeater_mode(repeater_mode),
    .half_duplex  (half_duplex),
    .tx           (tx),
    .rx           (rx),
    .hold_cycles  (hold_cycles),
    .crs          (crs),
    .col          (col),
    .crs_any      (crs_any),
    .col_any      (col_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all four outputs; the expected *_any values are derived from the
  // expected vectors.
  task automatic check_all(input string tag, input logic [3:0] exp_crs, input logic [3:0] exp_col);
    check({tag, ".crs"},     {28'd0, crs},     {28'd0, exp_crs});
    check({tag, ".col"},     {28'd0, col},     {28'd0, exp_col});
    check({tag, ".crs_any"}, {31'd0, crs_any}, {31'd0, |exp_crs});
    check({tag, ".col_any"}, {31'd0, col_any}, {31'd0, |exp_col});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; repeater_mode = 1'b0; half_duplex = 1'b0;
    tx = '0; rx = '0; hold_cycles = '0;
    #2;

    // Test 1: reset, hold=0, rx[0] high for 5 cycles.
    do_reset();
    check_all("t1_reset", 4'b0000, 4'b0000);
    rx = 4'b0001;
    check_all("t1_lag", 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("t1_on", 4'b0001, 4'b0000);
    end
    rx = '0;
    tick();
    check_all("t1_off", 4'b0000, 4'b0000);

    // Test 2: hold=3, tx[1] high for 4 cycles -> crs[1] high for 7 cycles.
    hold_cycles = 8'd3;
    tx = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_all("t2_on", 4'b0010, 4'b0000);
    end
    tx = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("t2_hold", 4'b0010, 4'b0000);
    end
    tick();
    check_all("t2_off", 4'b0000, 4'b0000);
    // Retrigger partway through the hold; the full hold then restarts.
    tx = 4'b0010; tick(); tick();
    tx = '0; tick(); tick();
    check_all("t2_mid_hold", 4'b0010, 4'b0000);
    tx = 4'b0010; tick();
    check_all("t2_retrig", 4'b0010, 4'b0000);
    tx = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("t2_rehold", 4'b0010, 4'b0000);
    end
    tick();
    check_all("t2_reoff", 4'b0000, 4'b0000);

    // Test 3: repeater mode. Own tx is ignored, and rx contention gives col.
    hold_cycles = 8'd0;
    repeater_mode = 1'b1;
    tx = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("t3_tx_ignored", 4'b0000, 4'b0000);
    end
    rx = 4'b0100;
    tick();
    check_all("t3_single_rx", 4'b0100, 4'b0000);
    rx = 4'b1001;
    tick();
    check_all("t3_contend0", 4'b1001, 4'b1001);
    tick();
    check_all("t3_contend1", 4'b1001, 4'b1001);
    rx = '0;
    tick();
    check_all("t3_stretch0", 4'b0000, 4'b1001);
    tick();
    check_all("t3_stretch1", 4'b0000, 4'b1001);
    tick();
    check_all("t3_col_off", 4'b0000, 4'b0000);
    tx = '0;
    repeater_mode = 1'b0;

    // Test 4: MAC half-duplex collision lasting 10 cycles; then full duplex.
    half_duplex = 1'b1;
    tx = 4'b0001; rx = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all("t4_hd", 4'b0001, 4'b0001);
    end
    tx = '0; rx = '0;
    tick();
    check_all("t4_hd_end", 4'b0000, 4'b0000);
    half_duplex = 1'b0;
    tx = 4'b0001; rx = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all("t4_fd", 4'b0001, 4'b0000);
    end
    tx = '0; rx = '0;
    tick();
    check_all("t4_fd_end", 4'b0000, 4'b0000);

    // Test 5: reset while crs[1] is in HOLD and col[1] is stretching.
    hold_cycles = 8'd5;
    half_duplex = 1'b1;
    tx = 4'b0010; rx = 4'b0010;
    tick();
    tx = '0; rx = '0;
    tick();
    check_all("t5_pre_reset", 4'b0010, 4'b0010);
    do_reset();
    check_all("t5_reset", 4'b0000, 4'b0000);
    half_duplex = 1'b0;
    hold_cycles = 8'd0;
    rx = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("t5_post_on", 4'b0010, 4'b0000);
    end
    rx = '0;
    tick();
    check_all("t5_post_off", 4'b0000, 4'b0000);

    // Test 6a: a change of hold_cycles during HOLD does not shorten the hold.
    hold_cycles = 8'd4;
    rx = 4'b0001;
    tick();
    rx = '0;
    tick();
    hold_cycles = 8'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("t6_hold_keep", 4'b0001, 4'b0000);
    end
    tick();
    check_all("t6_hold_end", 4'b0000, 4'b0000);

    // Test 6b: hold of 255 cycles.
    hold_cycles = 8'd255;
    rx = 4'b0001;
    tick();
    rx = '0;
    for (int k = 0; k < 255; k++) begin
      tick();
      check("t6_max_hold", {28'd0, crs}, 32'h1);
    end
    tick();
    check_all("t6_max_end", 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
